// File: rtl/elevator_pkg.sv
// Shared state encodings for the elevator scheduler and the floor counter,
// plus the default floor geometry.
package elevator_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      MOVE_UP   = 2'b01,
      MOVE_DOWN = 2'b10,
      DOOR_OPEN = 2'b11
   } elev_state_e;

   localparam int DEF_NUM_FLOORS = 4;
   localparam int DEF_FLOOR_W    = 2;

endpackage

// File: rtl/elevator_scheduler_door_timer.sv
// Door dwell counter: counts 0..DOOR_TIME-1 while run is high, done flags the
// final cycle. clear forces the count back to 0 and suppresses done.
module door_timer
   import elevator_pkg::*;
#(
   parameter int DOOR_TIME = 100,
   parameter int TIMER_W   = 7
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic clear,
   output logic done
);

   localparam logic [TIMER_W-1:0] LAST = TIMER_W'(DOOR_TIME - 1);

   logic [TIMER_W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || !run || clear)
         count <= '0;
      else if (count == LAST)
         count <= '0;
      else
         count <= count + 1'b1;
   end

   assign done = run && !clear && (count == LAST);

endmodule

// File: rtl/elevator_scheduler.sv
// LOOK-policy elevator request scheduler with door dwell timing.
// Optional ELEV_DOOR_HOLD_EN adds a door_hold input and restart-on-call.
module elevator_scheduler
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS = DEF_NUM_FLOORS,
   parameter int FLOOR_W    = DEF_FLOOR_W,
   parameter int DOOR_TIME  = 100,
   parameter int TIMER_W    = 7
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_FLOORS-1:0] req_btn,
   input  logic [FLOOR_W-1:0]    curr_floor,
   output logic [1:0]            current_state,
   output logic [NUM_FLOORS-1:0] req_pending,
   output logic                  door_open,
   output logic                  dir_up
`ifdef ELEV_DOOR_HOLD_EN
   ,input logic                  door_hold
`endif
);

   elev_state_e           state_q, state_n;
   logic                  dir_n;
   logic [FLOOR_W-1:0]    floor_q;
   logic [NUM_FLOORS-1:0] req_all, clr;
   logic                  here, above, below, at_top, at_bot, arrival;
   logic                  timer_clear, door_done;

   // Live buttons take part in the decision so a call is acted on the next cycle.
   always_comb begin
      req_all = req_pending | req_btn;
      here    = 1'b0;
      above   = 1'b0;
      below   = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (req_all[i]) begin
            if (int'(curr_floor) == i)     here  = 1'b1;
            else if (i > int'(curr_floor)) above = 1'b1;
            else                           below = 1'b1;
         end
      end
      at_top  = int'(curr_floor) >= NUM_FLOORS - 1;
      at_bot  = (curr_floor == '0);
      arrival = (curr_floor != floor_q);
   end

   always_comb begin
      state_n = state_q;
      dir_n   = dir_up;
      case (state_q)
         IDLE: begin
            if (here)                 state_n = DOOR_OPEN;
            else if (dir_up && above) state_n = MOVE_UP;
            else if (!dir_up && below) state_n = MOVE_DOWN;
            else if (above)           state_n = MOVE_UP;
            else if (below)           state_n = MOVE_DOWN;
         end
         MOVE_UP: begin
            if (arrival) begin
               if (here)                 state_n = DOOR_OPEN;
               else if (!above || at_top) state_n = IDLE;
            end else if (at_top) begin
               state_n = IDLE;
            end
         end
         MOVE_DOWN: begin
            if (arrival) begin
               if (here)                 state_n = DOOR_OPEN;
               else if (!below || at_bot) state_n = IDLE;
            end else if (at_bot) begin
               state_n = IDLE;
            end
         end
         DOOR_OPEN: begin
            if (door_done) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      if (state_n == MOVE_UP)   dir_n = 1'b1;
      if (state_n == MOVE_DOWN) dir_n = 1'b0;
   end

   // Clearing the current floor whenever the door is (or becomes) open absorbs
   // repeated presses there and lets the clear beat a same-cycle set.
   always_comb begin
      clr = '0;
      for (int i = 0; i < NUM_FLOORS; i++)
         clr[i] = (state_n == DOOR_OPEN) && (int'(curr_floor) == i);
   end

`ifdef ELEV_DOOR_HOLD_EN
   logic btn_here;
   always_comb begin
      btn_here = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++)
         if (req_btn[i] && int'(curr_floor) == i) btn_here = 1'b1;
   end
   assign timer_clear = (state_q == DOOR_OPEN) && (door_hold || btn_here);
`else
   assign timer_clear = 1'b0;
`endif

   door_timer #(
      .DOOR_TIME (DOOR_TIME),
      .TIMER_W   (TIMER_W)
   ) u_door_timer (
      .clk   (clk),
      .reset (reset),
      .run   (state_q == DOOR_OPEN),
      .clear (timer_clear),
      .done  (door_done)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         req_pending <= '0;
         door_open   <= 1'b0;
         dir_up      <= 1'b1;
         floor_q     <= curr_floor;
      end else begin
         state_q     <= state_n;
         req_pending <= req_all & ~clr;
         door_open   <= (state_n == DOOR_OPEN);
         dir_up      <= dir_n;
         floor_q     <= curr_floor;
      end
   end

   assign current_state = state_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler; the floor counter is played by the
// stimulus. Hold scenario runs only when ELEV_DOOR_HOLD_EN is defined.
module tb_elevator_scheduler;

   localparam int ST_IDLE = 0, ST_UP = 1, ST_DN = 2, ST_DOOR = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req_btn;
   logic [1:0] curr_floor;
   logic [1:0] current_state;
   logic [3:0] req_pending;
   logic       door_open;
   logic       dir_up;
`ifdef ELEV_DOOR_HOLD_EN
   logic       door_hold;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   elevator_scheduler dut (
      .clk           (clk),
      .reset         (reset),
      .req_btn       (req_btn),
      .curr_floor    (curr_floor),
      .current_state (current_state),
      .req_pending   (req_pending),
      .door_open     (door_open),
      .dir_up        (dir_up)
`ifdef ELEV_DOOR_HOLD_EN
      ,.door_hold    (door_hold)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called with the door just seen open; measures how long it stays open.
   // With absorb set, a call at the current floor is pressed mid-dwell.
   task automatic door_wait(input string tag, input bit absorb);
      int cnt;
      cnt = 1;
      while (cnt < 400) begin
         req_btn = (absorb && cnt == 50) ? (4'b0001 << curr_floor) : 4'b0000;
         step();
         if (current_state != 2'(ST_DOOR)) break;
         cnt++;
      end
      req_btn = 4'b0000;
      chk({tag, "_dur"}, cnt, 100);
      chk({tag, "_close"}, int'(current_state), ST_IDLE);
      chk({tag, "_door_low"}, int'(door_open), 0);
   endtask

   initial begin
      reset      = 1'b1;
      req_btn    = 4'b0000;
      curr_floor = 2'd0;
`ifdef ELEV_DOOR_HOLD_EN
      door_hold  = 1'b0;
`endif
      step();
      step();
      reset = 1'b0;
      chk("rst_state", int'(current_state), ST_IDLE);
      chk("rst_pend", int'(req_pending), 0);
      chk("rst_door", int'(door_open), 0);
      chk("rst_dir", int'(dir_up), 1);

      // 1: call at current floor opens door next cycle; press mid-dwell absorbed
      req_btn = 4'b0001;
      step();
      req_btn = 4'b0000;
      chk("t1_state", int'(current_state), ST_DOOR);
      chk("t1_door", int'(door_open), 1);
      chk("t1_pend", int'(req_pending), 0);
      door_wait("t1", 1'b1);
      chk("t1_pend_after", int'(req_pending), 0);

      // 2: 0 -> 3 passing 1 and 2
      req_btn = 4'b1000;
      step();
      req_btn = 4'b0000;
      chk("t2_up", int'(current_state), ST_UP);
      chk("t2_pend", int'(req_pending), 4'b1000);
      curr_floor = 2'd1; step();
      chk("t2_f1", int'(current_state), ST_UP);
      curr_floor = 2'd2; step();
      chk("t2_f2", int'(current_state), ST_UP);
      curr_floor = 2'd3; step();
      chk("t2_f3", int'(current_state), ST_DOOR);
      chk("t2_clr", int'(req_pending), 0);
      door_wait("t2", 1'b0);

      // 3: at floor 2 heading up, calls at 0 and 3 -> serve 3 first, then reverse
      curr_floor = 2'd2; step();
      req_btn = 4'b1001;
      step();
      req_btn = 4'b0000;
      chk("t3_up", int'(current_state), ST_UP);
      chk("t3_dir", int'(dir_up), 1);
      chk("t3_pend", int'(req_pending), 4'b1001);
      curr_floor = 2'd3; step();
      chk("t3_f3", int'(current_state), ST_DOOR);
      chk("t3_pend3", int'(req_pending), 4'b0001);
      door_wait("t3a", 1'b0);
      step();
      chk("t3_down", int'(current_state), ST_DN);
      chk("t3_dir_dn", int'(dir_up), 0);
      curr_floor = 2'd2; step();
      chk("t3_f2", int'(current_state), ST_DN);
      curr_floor = 2'd1; step();
      chk("t3_f1", int'(current_state), ST_DN);
      curr_floor = 2'd0; step();
      chk("t3_f0", int'(current_state), ST_DOOR);
      door_wait("t3b", 1'b0);
      step();
      chk("t3_rest", int'(current_state), ST_IDLE);
      chk("t3_rest_dir", int'(dir_up), 0);

      // 4: call at 1 arrives while heading from 0 to 3
      req_btn = 4'b1000;
      step();
      chk("t4_up", int'(current_state), ST_UP);
      chk("t4_dir", int'(dir_up), 1);
      req_btn = 4'b0010;
      step();
      req_btn = 4'b0000;
      chk("t4_hold", int'(current_state), ST_UP);
      chk("t4_pend", int'(req_pending), 4'b1010);
      curr_floor = 2'd1; step();
      chk("t4_stop1", int'(current_state), ST_DOOR);
      chk("t4_pend1", int'(req_pending), 4'b1000);
      door_wait("t4a", 1'b0);
      chk("t4_keep", int'(req_pending), 4'b1000);
      step();
      chk("t4_resume", int'(current_state), ST_UP);
      curr_floor = 2'd2; step();
      chk("t4_f2", int'(current_state), ST_UP);
      curr_floor = 2'd3; step();
      chk("t4_f3", int'(current_state), ST_DOOR);
      door_wait("t4b", 1'b0);

      // 5: reset while moving down with calls 0 and 2 pending
      req_btn = 4'b0101;
      step();
      req_btn = 4'b0000;
      chk("t5_down", int'(current_state), ST_DN);
      chk("t5_pend", int'(req_pending), 4'b0101);
      chk("t5_dir", int'(dir_up), 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t5_state", int'(current_state), ST_IDLE);
      chk("t5_pend0", int'(req_pending), 0);
      chk("t5_door", int'(door_open), 0);
      chk("t5_dir1", int'(dir_up), 1);
      step();
      chk("t5_stay", int'(current_state), ST_IDLE);

      // reset in the middle of a door dwell
      req_btn = 4'b1000;
      step();
      req_btn = 4'b0000;
      for (int i = 0; i < 10; i++) step();
      chk("rd_open", int'(door_open), 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rd_state", int'(current_state), ST_IDLE);
      chk("rd_door", int'(door_open), 0);

`ifdef ELEV_DOOR_HOLD_EN
      // 6: door held for 300 cycles, then full dwell after release
      curr_floor = 2'd2; step();
      req_btn = 4'b0100;
      door_hold = 1'b1;
      step();
      req_btn = 4'b0000;
      for (int i = 0; i < 299; i++) step();
      chk("t6_held", int'(current_state), ST_DOOR);
      door_hold = 1'b0;
      begin
         int cnt;
         cnt = 0;
         while (cnt < 400) begin
            step();
            if (current_state != 2'(ST_DOOR)) break;
            cnt++;
         end
         chk("t6_release", cnt, 99);
         chk("t6_close", int'(current_state), ST_IDLE);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
